// File: rtl/seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_scheduler
//  Description : Time-multiplexed scan scheduler for a 4-digit common-anode
//                7-segment display. Double-buffers 16-bit hex words taken
//                over valid/ready, drives one digit per slot with an optional
//                all-off blanking gap, and swaps words only at frame ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_scheduler #(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an,
    output logic        frame_done
);

    // Counter only ever counts up to (slot length - 1), then reloads.
    localparam int c_CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_TICK_LAST  = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST =
        c_CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic c_HAS_BLANK = (BLANK_CYCLES > 0);

    typedef enum logic [0:0] {
        S_DRIVE = 1'b0,
        S_BLANK = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_dig, w_dig_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                 w_frame_end;

    logic [15:0]          r_pend;
    logic [3:0]           r_pend_dp;
    logic                 r_pend_valid;
    logic [15:0]          r_disp;
    logic [3:0]           r_dp;

    logic                 w_xfer;
    logic                 w_load;
    logic [15:0]          w_disp_nxt;
    logic [3:0]           w_dp_nxt;
    logic [3:0]           w_supp;
    logic [3:0]           w_nib;

    logic [3:0]           w_an_nxt;
    logic [6:0]           w_seg_nxt;
    logic                 w_dpn_nxt;

    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_dpn;
    logic                 r_frame_done;

    // Hex to active-low segment pattern, bit 6 = g .. bit 0 = a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Pending slot is the only back-pressure; refuse words while in reset.
    assign din_ready = ~r_pend_valid & ~rst;
    assign w_xfer    = din_valid & din_ready;

    // Scan FSM state register: digit index, slot phase and tick counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_DRIVE;
            r_dig   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dig   <= w_dig_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: DRIVE -> BLANK -> next digit's DRIVE; frame ends after digit 3.
    always_comb begin
        w_state_nxt = r_state;
        w_dig_nxt   = r_dig;
        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        w_frame_end = 1'b0;
        case (r_state)
            S_DRIVE: begin
                if (r_cnt == c_TICK_LAST) begin
                    w_cnt_nxt = '0;
                    if (c_HAS_BLANK) begin
                        w_state_nxt = S_BLANK;
                    end else begin
                        w_dig_nxt   = r_dig + 2'd1;
                        w_frame_end = (r_dig == 2'd3);
                    end
                end
            end
            S_BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRIVE;
                    w_dig_nxt   = r_dig + 2'd1;
                    w_frame_end = (r_dig == 2'd3);
                end
            end
            default: begin
                w_state_nxt = S_DRIVE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The word shown from the next edge on: the pending word replaces it at a frame end.
    assign w_load     = w_frame_end & r_pend_valid;
    assign w_disp_nxt = w_load ? r_pend    : r_disp;
    assign w_dp_nxt   = w_load ? r_pend_dp : r_dp;

    // Leading zeros propagate down from digit 3; digit 0 is never suppressed.
    assign w_supp[3] = lz_en     & (w_disp_nxt[15:12] == 4'h0);
    assign w_supp[2] = w_supp[3] & (w_disp_nxt[11:8]  == 4'h0);
    assign w_supp[1] = w_supp[2] & (w_disp_nxt[7:4]   == 4'h0);
    assign w_supp[0] = 1'b0;

    assign w_nib = w_disp_nxt[{w_dig_nxt, 2'b00} +: 4];

    // Output pattern for the upcoming state, so pins change on the same edge as the FSM.
    always_comb begin
        w_an_nxt  = 4'hF;
        w_seg_nxt = 7'h7F;
        w_dpn_nxt = 1'b1;
        if ((w_state_nxt == S_DRIVE) && !w_supp[w_dig_nxt]) begin
            w_an_nxt  = ~(4'b0001 << w_dig_nxt);
            w_seg_nxt = hex_to_seg(w_nib);
            w_dpn_nxt = ~w_dp_nxt[w_dig_nxt];
        end
    end

    // Double buffer: capture into pending, promote to display at a frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend       <= 16'h0000;
            r_pend_dp    <= 4'h0;
            r_pend_valid <= 1'b0;
            r_disp       <= 16'h0000;
            r_dp         <= 4'h0;
        end else begin
            if (w_load) begin
                r_disp       <= r_pend;
                r_dp         <= r_pend_dp;
                r_pend_valid <= 1'b0;
            end
            if (w_xfer) begin
                r_pend       <= din;
                r_pend_dp    <= dp_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

    // Registered display pins and the end-of-frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an         <= 4'hF;
            r_seg        <= 7'h7F;
            r_dpn        <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_dpn        <= w_dpn_nxt;
            r_frame_done <= w_frame_end;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp_n       = r_dpn;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_scheduler
//  Description : Self-checking bench for seg_scan_scheduler with TICK_DIV=4,
//                BLANK_CYCLES=2 (24-cycle frame). Cycle 0 is the first cycle
//                after reset release; slot i of a frame starts at 6*i.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        lz_en = 1'b0;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seg_scan_scheduler #(
        .TICK_DIV     (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .dp_in      (dp_in),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Display vector: per-digit expectations packed digit3..digit0.
    typedef struct packed {
        logic [15:0] din;
        logic [3:0]  dp;
        logic        lz;
        logic [15:0] an_exp;
        logic [27:0] seg_exp;
        logic [3:0]  dpn_exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        din_valid = 1'b0;
        step();
        step();
        chk("rst_an",    {12'h0, an},          16'h000F);
        chk("rst_seg",   {9'h0, seg},          16'h007F);
        chk("rst_dpn",   {15'h0, dp_n},        16'h0001);
        chk("rst_fd",    {15'h0, frame_done},  16'h0000);
        chk("rst_ready", {15'h0, din_ready},   16'h0000);
        rst = 1'b0;
        cyc = 0;
        #1;
        chk("rel_ready", {15'h0, din_ready},   16'h0001);
    endtask

    function automatic logic [3:0] exp_an_blank_disp(input int c);
        int p, slot, off;
        if (c == 0) return 4'hF;
        p    = c % 24;
        slot = p / 6;
        off  = p % 6;
        if (off < 4) return ~(4'b0001 << slot);
        return 4'hF;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h12AF, 4'h0, 1'b0, 16'h7BDE, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
        vecs[1] = '{16'h0050, 4'h0, 1'b1, 16'hFFDE, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
        vecs[2] = '{16'h0050, 4'h0, 1'b0, 16'h7BDE, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF};
        vecs[3] = '{16'h0000, 4'hF, 1'b1, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hE};
        vecs[4] = '{16'h3456, 4'h5, 1'b1, 16'h7BDE, {7'h30, 7'h19, 7'h12, 7'h02}, 4'hA};
        vecs[5] = '{16'h789B, 4'h8, 1'b0, 16'h7BDE, {7'h78, 7'h00, 7'h10, 7'h03}, 4'h7};
        vecs[6] = '{16'hCDEF, 4'h2, 1'b1, 16'h7BDE, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'hD};
        vecs[7] = '{16'h0100, 4'h0, 1'b1, 16'hFBDE, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'hF};
        vecs[8] = '{16'h0003, 4'hF, 1'b1, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h30}, 4'hE};
        vecs[9] = '{16'h0100, 4'hF, 1'b1, 16'hFBDE, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'h8};

        // Idle scan after reset: anode sequence, blank segments, frame pulses.
        do_reset();
        for (int c = 0; c < 50; c++) begin
            run_to(c);
            chk($sformatf("idle_an_c%0d", c), {12'h0, an}, {12'h0, exp_an_blank_disp(c)});
            chk($sformatf("idle_seg_c%0d", c), {9'h0, seg},
                (exp_an_blank_disp(c) == 4'hF) ? 16'h007F : 16'h0040);
            chk($sformatf("idle_fd_c%0d", c), {15'h0, frame_done},
                (c > 0 && c % 24 == 0) ? 16'h0001 : 16'h0000);
        end

        // Table: load word at cycle 0, check every digit of the second frame.
        for (int v = 0; v < 10; v++) begin
            lz_en = vecs[v].lz;
            do_reset();
            din       = vecs[v].din;
            dp_in     = vecs[v].dp;
            din_valid = 1'b1;
            step();
            din_valid = 1'b0;
            chk($sformatf("v%0d_ready_busy", v), {15'h0, din_ready}, 16'h0000);
            run_to(24);
            chk($sformatf("v%0d_fd", v),    {15'h0, frame_done}, 16'h0001);
            chk($sformatf("v%0d_ready", v), {15'h0, din_ready},  16'h0001);
            for (int i = 0; i < 4; i++) begin
                run_to(24 + 6 * i + 1);
                chk($sformatf("v%0d_an_d%0d", v, i),  {12'h0, an},  {12'h0, vecs[v].an_exp[4*i +: 4]});
                chk($sformatf("v%0d_seg_d%0d", v, i), {9'h0, seg},  {9'h0, vecs[v].seg_exp[7*i +: 7]});
                chk($sformatf("v%0d_dpn_d%0d", v, i), {15'h0, dp_n}, {15'h0, vecs[v].dpn_exp[i]});
                run_to(24 + 6 * i + 4);
                chk($sformatf("v%0d_blank_an_d%0d", v, i),  {12'h0, an},  16'h000F);
                chk($sformatf("v%0d_blank_seg_d%0d", v, i), {9'h0, seg},  16'h007F);
            end
        end
        lz_en = 1'b0;
        dp_in = 4'h0;

        // Capture mid-frame: ready drops until the frame pulse.
        do_reset();
        run_to(3);
        din = 16'h12AF; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("mid_ready_low", {15'h0, din_ready}, 16'h0000);
        run_to(23);
        chk("mid_ready_low23", {15'h0, din_ready}, 16'h0000);
        run_to(24);
        chk("mid_fd",    {15'h0, frame_done}, 16'h0001);
        chk("mid_ready", {15'h0, din_ready},  16'h0001);
        run_to(25);
        chk("mid_seg_d0", {9'h0, seg}, 16'h000E);

        // Capture on the frame_done cycle: shown only after the next pulse.
        do_reset();
        din = 16'h1111; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        run_to(24);
        din = 16'h2222; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("fdcap_ready", {15'h0, din_ready}, 16'h0000);
        chk("fdcap_seg_f2", {9'h0, seg}, 16'h0079);
        run_to(48);
        chk("fdcap_fd2", {15'h0, frame_done}, 16'h0001);
        run_to(49);
        chk("fdcap_seg_f3", {9'h0, seg}, 16'h0024);

        // Capture on the boundary cycle itself with pending empty.
        do_reset();
        run_to(23);
        din = 16'h3333; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("bcap_ready", {15'h0, din_ready}, 16'h0000);
        run_to(25);
        chk("bcap_seg_f2", {9'h0, seg}, 16'h0040);
        run_to(48);
        chk("bcap_ready48", {15'h0, din_ready}, 16'h0001);
        run_to(49);
        chk("bcap_seg_f3", {9'h0, seg}, 16'h0030);

        // Back-to-back words: second is held off, then shown a frame later.
        do_reset();
        din = 16'h4444; din_valid = 1'b1;
        step();
        din = 16'h5555;
        chk("b2b_ready1", {15'h0, din_ready}, 16'h0000);
        run_to(23);
        chk("b2b_ready23", {15'h0, din_ready}, 16'h0000);
        run_to(24);
        chk("b2b_ready24", {15'h0, din_ready}, 16'h0001);
        step();
        din_valid = 1'b0;
        chk("b2b_ready25", {15'h0, din_ready}, 16'h0000);
        chk("b2b_seg_f2",  {9'h0, seg}, 16'h0019);
        run_to(48);
        chk("b2b_ready48", {15'h0, din_ready}, 16'h0001);
        run_to(49);
        chk("b2b_seg_f3",  {9'h0, seg}, 16'h0012);

        // Reset mid-slot with a word pending: it must be discarded.
        do_reset();
        din = 16'h8888; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        run_to(25);
        din = 16'h9999; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        run_to(32);
        chk("mrst_pre_an",  {12'h0, an},  16'h000D);
        chk("mrst_pre_seg", {9'h0, seg},  16'h0000);
        rst = 1'b1;
        step();
        chk("mrst_an",    {12'h0, an},        16'h000F);
        chk("mrst_seg",   {9'h0, seg},        16'h007F);
        chk("mrst_ready", {15'h0, din_ready}, 16'h0000);
        rst = 1'b0;
        cyc = 0;
        #1;
        chk("mrst_rel_ready", {15'h0, din_ready}, 16'h0001);
        run_to(1);
        chk("mrst_an_c1",  {12'h0, an},  16'h000E);
        chk("mrst_seg_c1", {9'h0, seg},  16'h0040);
        run_to(6);
        chk("mrst_an_c6",  {12'h0, an},  16'h000D);
        run_to(24);
        chk("mrst_fd",     {15'h0, frame_done}, 16'h0001);
        run_to(25);
        chk("mrst_seg_f2", {9'h0, seg}, 16'h0040);
        chk("mrst_an_f2",  {12'h0, an}, 16'h000E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
